lcd_dist_update_ctrl: RTL and testbench

- Sequences distance updates for the LCD overlay, all in the pixel clock domain.
- Pops byte pairs (high byte first) from the core-to-LCD async distance FIFO, using its read side in standard, non-FWFT mode.
- Assembles a 12-bit binary value and hands it to the binary-to-BCD converter using the converter's valid/ready protocol.
- Holds the BCD result until the next frame start (vs rising edge), then commits it to the character array. The displayed digits therefore never change mid-frame.

---
 rtl/lcd_dist_update_ctrl_if.sv | 32 +++
 rtl/lcd_dist_update_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lcd_dist_update_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_dist_update_ctrl_if.sv
// Port bundle for lcd_dist_update_ctrl: distance FIFO read side, binary-to-BCD
// converter handshake, frame sync input and the committed-display outputs.
// The controller connects through the master modport. The environment
// (FIFO, converter, timing generator, character array) uses the slave modport.
interface lcd_dist_update_ctrl_if;
  logic        fifo_empty_i;
  logic        fifo_rden_o;
  logic [7:0]  fifo_dout_i;
  logic        bcd_ready_i;
  logic        bin_valid_o;
  logic [11:0] bin_o;
  logic        bcd_valid_i;
  logic [15:0] bcd_i;
  logic        vs_i;
  logic [15:0] disp_value_o;
  logic        disp_valid_o;
  logic        busy_o;
  logic [15:0] upd_cnt_o;
  logic [15:0] drop_cnt_o;

  modport master (
    input  fifo_empty_i, fifo_dout_i, bcd_ready_i, bcd_valid_i, bcd_i, vs_i,
    output fifo_rden_o, bin_valid_o, bin_o, disp_value_o, disp_valid_o,
           busy_o, upd_cnt_o, drop_cnt_o
  );

  modport slave (
    output fifo_empty_i, fifo_dout_i, bcd_ready_i, bcd_valid_i, bcd_i, vs_i,
    input  fifo_rden_o, bin_valid_o, bin_o, disp_value_o, disp_valid_o,
           busy_o, upd_cnt_o, drop_cnt_o
  );
endinterface

// File: rtl/lcd_dist_update_ctrl.sv
// lcd_dist_update_ctrl: distance update sequencer for the LCD overlay.
// The controller reads a high/low byte pair from the distance FIFO, which is
// used in standard (non-FWFT) mode. It builds a 12-bit value and passes it to
// the binary-to-BCD converter. It holds the BCD result and commits it to the
// display only on a frame-start edge of vs_i, so the digits never change in
// the middle of a frame.
// Optional build macro: LCD_DIST_UPD_STAT_EN enables the saturating update and
// drop counters. Without the macro, upd_cnt_o and drop_cnt_o read 16'h0000.
module lcd_dist_update_ctrl #(
  parameter logic [15:0] RESET_VALUE  = 16'h6789,
  parameter int unsigned PAIR_TIMEOUT = 1024,
  parameter logic        VS_POL       = 1'b1
) (
  input  logic                          lcd_clk,
  input  logic                          rst_n,
  lcd_dist_update_ctrl_if.master        bus
);

  localparam logic [15:0] TIMER_LAST = 16'(PAIR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_HI   = 3'd1,
    ST_CAP_HI  = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_RD_LO   = 3'd4,
    ST_CAP_LO  = 3'd5,
    ST_CONV    = 3'd6,
    ST_HOLD    = 3'd7
  } state_t;

  state_t      state_r, state_s;
  logic        vs_d_r;
  logic        vs_edge_s;
  // Only the low nibble of the high byte contributes to the 12-bit value.
  logic [3:0]  hi_r, hi_s;
  logic [15:0] timer_r, timer_s;
  logic        rden_r, rden_s;
  logic [11:0] bin_r, bin_s;
  logic        bin_valid_r, bin_valid_s;
  logic [15:0] pending_r, pending_s;
  logic [15:0] disp_value_r, disp_value_s;
  logic        disp_valid_r, disp_valid_s;
  logic        busy_r;
  logic        upd_inc_s, drop_inc_s;
  logic [3:0]  unused_hi_nibble_s;

  assign unused_hi_nibble_s = bus.fifo_dout_i[7:4];
  assign vs_edge_s = (bus.vs_i == VS_POL) && (vs_d_r != VS_POL);

  // Next-state and next-register computation for the update sequencer.
  always_comb begin
    state_s      = state_r;
    hi_s         = hi_r;
    timer_s      = timer_r;
    rden_s       = 1'b0;
    bin_s        = bin_r;
    bin_valid_s  = 1'b0;
    pending_s    = pending_r;
    disp_value_s = disp_value_r;
    disp_valid_s = 1'b0;
    upd_inc_s    = 1'b0;
    drop_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!bus.fifo_empty_i && bus.bcd_ready_i) begin
          rden_s  = 1'b1;
          state_s = ST_RD_HI;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_HI: begin
        state_s = ST_CAP_HI;
      end
      ST_CAP_HI: begin
        hi_s    = bus.fifo_dout_i[3:0];
        timer_s = 16'd0;
        state_s = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!bus.fifo_empty_i) begin
          rden_s  = 1'b1;
          state_s = ST_RD_LO;
        end else if (timer_r == TIMER_LAST) begin
          // The low byte never arrived, so the orphaned high byte is dropped.
          hi_s       = 4'h0;
          drop_inc_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      ST_RD_LO: begin
        state_s = ST_CAP_LO;
      end
      ST_CAP_LO: begin
        bin_s       = {hi_r, bus.fifo_dout_i};
        bin_valid_s = 1'b1;
        state_s     = ST_CONV;
      end
      ST_CONV: begin
        if (bus.bcd_valid_i) begin
          pending_s = bus.bcd_i;
          state_s   = ST_HOLD;
        end else begin
          state_s = ST_CONV;
        end
      end
      ST_HOLD: begin
        if (vs_edge_s) begin
          disp_value_s = pending_r;
          disp_valid_s = 1'b1;
          upd_inc_s    = 1'b1;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers, updated from the next-state logic.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      vs_d_r       <= ~VS_POL;
      hi_r         <= 4'h0;
      timer_r      <= 16'd0;
      rden_r       <= 1'b0;
      bin_r        <= 12'h000;
      bin_valid_r  <= 1'b0;
      pending_r    <= 16'h0000;
      disp_value_r <= RESET_VALUE;
      disp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      vs_d_r       <= bus.vs_i;
      hi_r         <= hi_s;
      timer_r      <= timer_s;
      rden_r       <= rden_s;
      bin_r        <= bin_s;
      bin_valid_r  <= bin_valid_s;
      pending_r    <= pending_s;
      disp_value_r <= disp_value_s;
      disp_valid_r <= disp_valid_s;
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign bus.fifo_rden_o  = rden_r;
  assign bus.bin_o        = bin_r;
  assign bus.bin_valid_o  = bin_valid_r;
  assign bus.disp_value_o = disp_value_r;
  assign bus.disp_valid_o = disp_valid_r;
  assign bus.busy_o       = busy_r;

`ifdef LCD_DIST_UPD_STAT_EN
  logic [15:0] upd_cnt_r;
  logic [15:0] drop_cnt_r;

  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_cnt_r  <= 16'h0000;
      drop_cnt_r <= 16'h0000;
    end else begin
      if (upd_inc_s && (upd_cnt_r != 16'hFFFF)) begin
        upd_cnt_r <= upd_cnt_r + 16'd1;
      end else begin
        upd_cnt_r <= upd_cnt_r;
      end
      if (drop_inc_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign bus.upd_cnt_o  = upd_cnt_r;
  assign bus.drop_cnt_o = drop_cnt_r;
`else
  logic unused_stat_s;
  assign unused_stat_s  = upd_inc_s ^ drop_inc_s;
  assign bus.upd_cnt_o  = 16'h0000;
  assign bus.drop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_dist_update_ctrl.sv
// Directed testbench for lcd_dist_update_ctrl. It models the non-FWFT distance
// FIFO and plays the converter and timing generator from one linear sequence.
module tb_lcd_dist_update_ctrl;
  logic lcd_clk = 1'b0;
  logic rst_n;

  lcd_dist_update_ctrl_if bus ();

  lcd_dist_update_ctrl #(
    .RESET_VALUE (16'h6789),
    .PAIR_TIMEOUT(16),
    .VS_POL      (1'b1)
  ) dut (
    .lcd_clk(lcd_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 lcd_clk = ~lcd_clk;

`ifdef LCD_DIST_UPD_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic [7:0]  fifo_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          bin_cnt = 0;
  int          disp_cnt = 0;
  int          rden_cnt = 0;
  int          rd_empty_err = 0;
  logic [11:0] last_bin = 12'h000;

  // Non-FWFT FIFO model: data appears the cycle after a read; empty is registered.
  always @(posedge lcd_clk) begin
    if (bus.fifo_rden_o === 1'b1) begin
      if (fifo_q.size() == 0) rd_empty_err++;
      else bus.fifo_dout_i <= fifo_q.pop_front();
    end
    bus.fifo_empty_i <= (fifo_q.size() == 0);
  end

  // Event monitor: counts pulses held during the cycle just ended.
  always @(posedge lcd_clk) begin
    if (rst_n === 1'b1) begin
      if (bus.bin_valid_o === 1'b1) begin
        bin_cnt++;
        last_bin = bus.bin_o;
      end
      if (bus.disp_valid_o === 1'b1) disp_cnt++;
      if (bus.fifo_rden_o === 1'b1) rden_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge lcd_clk);
  endtask

  task automatic wait_bin(input int target, input int budget);
    for (int i = 0; i < budget && bin_cnt < target; i++) @(negedge lcd_clk);
    chk("bin_valid_count", bin_cnt, target);
  endtask

  task automatic convert(input logic [15:0] val);
    bus.bcd_valid_i = 1'b1;
    bus.bcd_i       = val;
    tick(1);
    bus.bcd_valid_i = 1'b0;
  endtask

  task automatic frame();
    bus.vs_i = 1'b1;
    tick(3);
    bus.vs_i = 1'b0;
    tick(3);
  endtask

  logic [7:0]  pair_hi  [3] = '{8'h01, 8'h02, 8'h0F};
  logic [7:0]  pair_lo  [3] = '{8'h00, 8'h9A, 8'hFF};
  logic [11:0] exp_bin  [3] = '{12'h100, 12'h29A, 12'hFFF};
  logic [15:0] exp_bcd  [3] = '{16'h0256, 16'h0666, 16'h4095};

  initial begin
    rst_n           = 1'b0;
    bus.vs_i        = 1'b0;
    bus.bcd_ready_i = 1'b1;
    bus.bcd_valid_i = 1'b0;
    bus.bcd_i       = 16'h0000;
    tick(3);
    chk("rst_disp_value", bus.disp_value_o, 16'h6789);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_rden", bus.fifo_rden_o, 1'b0);
    chk("rst_bin", bus.bin_o, 12'h000);
    chk("rst_bin_valid", bus.bin_valid_o, 1'b0);
    chk("rst_disp_valid", bus.disp_valid_o, 1'b0);
    chk("rst_upd_cnt", bus.upd_cnt_o, 16'h0000);
    chk("rst_drop_cnt", bus.drop_cnt_o, 16'h0000);
    rst_n = 1'b1;
    tick(2);

    // Idle frames with an empty FIFO change nothing.
    repeat (3) frame();
    chk("idle_disp_value", bus.disp_value_o, 16'h6789);
    chk("idle_busy", bus.busy_o, 1'b0);
    chk("idle_rden_cnt", rden_cnt, 0);
    chk("idle_disp_cnt", disp_cnt, 0);

    // First pair 04 D2, then a commit on the next frame start.
    fifo_q.push_back(8'h04);
    fifo_q.push_back(8'hD2);
    wait_bin(1, 30);
    chk("pair1_bin", last_bin, 12'h4D2);
    tick(20);
    chk("pair1_single_pulse", bin_cnt, 1);
    chk("pair1_busy_conv", bus.busy_o, 1'b1);
    chk("pair1_disp_before", bus.disp_value_o, 16'h6789);
    convert(16'h1234);
    tick(2);
    chk("hold_disp_unchanged", bus.disp_value_o, 16'h6789);
    chk("hold_no_commit", disp_cnt, 0);
    bus.vs_i = 1'b1;
    chk("commit_not_before_edge", bus.disp_valid_o, 1'b0);
    tick(1);
    chk("commit_value", bus.disp_value_o, 16'h1234);
    chk("commit_pulse", bus.disp_valid_o, 1'b1);
    tick(1);
    chk("commit_pulse_width", bus.disp_valid_o, 1'b0);
    bus.vs_i = 1'b0;
    tick(2);
    chk("commit_count", disp_cnt, 1);

    // Pair F0 0A: upper nibble masked. bcd_valid and a vs edge coincide.
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'h0A);
    wait_bin(2, 30);
    chk("mask_bin", last_bin, 12'h00A);
    bus.vs_i = 1'b1;
    convert(16'h0010);
    tick(4);
    chk("same_cycle_edge_value", bus.disp_value_o, 16'h1234);
    chk("same_cycle_edge_count", disp_cnt, 1);
    bus.vs_i = 1'b0;
    tick(2);
    bus.vs_i = 1'b1;
    tick(1);
    chk("mask_commit_value", bus.disp_value_o, 16'h0010);
    chk("mask_commit_pulse", bus.disp_valid_o, 1'b1);
    bus.vs_i = 1'b0;
    tick(2);

    // Lone high byte: the timeout fires after 16 empty WAIT_LO cycles.
    fifo_q.push_back(8'h01);
    tick(19);
    chk("timeout_busy_before", bus.busy_o, 1'b1);
    tick(1);
    chk("timeout_busy_after", bus.busy_o, 1'b0);
    tick(2);
    chk("timeout_no_bin", bin_cnt, 2);
    chk("timeout_drop_cnt", bus.drop_cnt_o, STAT ? 16'd1 : 16'd0);
    chk("timeout_rden_cnt", rden_cnt, 5);

    // Three pairs back-to-back: one commit per frame, in FIFO order.
    for (int i = 0; i < 3; i++) begin
      fifo_q.push_back(pair_hi[i]);
      fifo_q.push_back(pair_lo[i]);
    end
    for (int i = 0; i < 3; i++) begin
      wait_bin(3 + i, 40);
      chk("burst_bin", last_bin, exp_bin[i]);
      convert(exp_bcd[i]);
      tick(5);
      chk("burst_no_read_in_hold", rden_cnt, 5 + 2 * (i + 1));
      chk("burst_busy_hold", bus.busy_o, 1'b1);
      bus.vs_i = 1'b1;
      tick(1);
      chk("burst_commit_value", bus.disp_value_o, exp_bcd[i]);
      chk("burst_commit_pulse", bus.disp_valid_o, 1'b1);
      bus.vs_i = 1'b0;
      tick(2);
    end
    chk("burst_commit_count", disp_cnt, 5);
    chk("burst_upd_cnt", bus.upd_cnt_o, STAT ? 16'd5 : 16'd0);

    // Converter not ready: no reads until bcd_ready_i rises.
    bus.bcd_ready_i = 1'b0;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h07);
    tick(10);
    chk("not_ready_rden_cnt", rden_cnt, 11);
    chk("not_ready_busy", bus.busy_o, 1'b0);
    bus.bcd_ready_i = 1'b1;
    wait_bin(6, 30);
    chk("ready_bin", last_bin, 12'h007);
    convert(16'h0007);
    tick(2);
    chk("pre_reset_busy", bus.busy_o, 1'b1);

    // Reset while in HOLD: the pending value is lost immediately.
    rst_n = 1'b0;
    #1;
    chk("hold_reset_disp", bus.disp_value_o, 16'h6789);
    chk("hold_reset_busy", bus.busy_o, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_reset_upd_cnt", bus.upd_cnt_o, 16'h0000);
    chk("post_reset_drop_cnt", bus.drop_cnt_o, 16'h0000);
    frame();
    chk("post_reset_pending_lost", bus.disp_value_o, 16'h6789);
    chk("post_reset_no_commit", disp_cnt, 5);
    chk("read_while_empty", rd_empty_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog against a hung sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
